// File: rtl/snes_pad_responder.sv
// Controller-side SNES joypad emulator: captures a 16-bit button vector on host latch
// and shifts it out active-low, one bit per synchronized host clock rising edge.
module snes_pad_responder #(
   parameter int   SYNC_STAGES = 2,
   parameter int   NUM_BITS    = 16,
   parameter logic TAIL_LEVEL  = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] button_state,
   input  logic        controller_latch,
   input  logic        controller_clock,
   output logic        controller_data,
   output logic [4:0]  bit_count,
   output logic        frame_done,
   output logic        overrun,
   output logic [15:0] snapshot,
   output logic [1:0]  fsm_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2
   } state_e;

   localparam logic [4:0] LAST_COUNT = 5'(NUM_BITS);

   // Reset asserts asynchronously but is released on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rst_sync_q <= 2'b11;
      else       rst_sync_q <= {rst_sync_q[0], 1'b0};
   end

   assign rst_int = rst_sync_q[1];

   logic [SYNC_STAGES-1:0] latch_sync_q;
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic                   latch_prev_q;
   logic                   clk_prev_q;

   // Idle pin levels are the reset values so release never manufactures an edge.
   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         latch_sync_q <= '0;
         clk_sync_q   <= '1;
         latch_prev_q <= 1'b0;
         clk_prev_q   <= 1'b1;
      end else begin
         latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], controller_latch};
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], controller_clock};
         latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
         clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   logic latch_s;
   logic latch_fall;
   logic clk_rise;

   assign latch_s    = latch_sync_q[SYNC_STAGES-1];
   assign latch_fall = ~latch_s & latch_prev_q;
   assign clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

   state_e      state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [4:0]  count_q, count_d;
   logic [15:0] snap_q, snap_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;

   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         state_q <= S_IDLE;
         shift_q <= 16'hFFFF;
         count_q <= 5'd0;
         snap_q  <= 16'h0000;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
         snap_q  <= snap_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   // Latch has priority over any clock edge; a clock edge under latch is an overrun.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      snap_d  = snap_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      if (latch_s) begin
         state_d = S_LOAD;
         shift_d = ~button_state;
         count_d = 5'd0;
         ovr_d   = clk_rise;
      end else if (latch_fall) begin
         state_d = S_SHIFT;
         shift_d = ~button_state;
         snap_d  = button_state;
         count_d = 5'd0;
      end else if (clk_rise) begin
         if (state_q == S_SHIFT) begin
            shift_d = {TAIL_LEVEL, shift_q[15:1]};
            count_d = count_q + 5'd1;
            if (count_q + 5'd1 == LAST_COUNT) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end else if (state_q == S_IDLE && count_q == LAST_COUNT) begin
            // Only a completed frame drains tail bits; post-reset idle keeps driving 1s.
            shift_d = {TAIL_LEVEL, shift_q[15:1]};
         end
      end
   end

   assign controller_data = shift_q[0];
   assign bit_count       = count_q;
   assign frame_done      = done_q;
   assign overrun         = ovr_q;
   assign snapshot        = snap_q;
   assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: table of whole frames plus hand-written
// sequences for abort, overrun, and mid-frame reset.
module tb_snes_pad_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] button_state;
   logic        latch;
   logic        cclk;
   logic        data;
   logic [4:0]  bit_count;
   logic        frame_done;
   logic        overrun;
   logic [15:0] snapshot;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int ov_cnt = 0;

   always #15 clk = ~clk;

   snes_pad_responder dut (
      .clock            (clk),
      .reset            (reset),
      .button_state     (button_state),
      .controller_latch (latch),
      .controller_clock (cclk),
      .controller_data  (data),
      .bit_count        (bit_count),
      .frame_done       (frame_done),
      .overrun          (overrun),
      .snapshot         (snapshot),
      .fsm_state_o      (fsm_state)
   );

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   typedef struct {
      logic [15:0] buttons;
      int          pulses;
      logic [31:0] exp_bits;
      logic [4:0]  exp_count;
      int          exp_done;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic latch_pulse();
      latch = 1'b1;
      cycles(50);
      latch = 1'b0;
      cycles(50);
   endtask

   task automatic clock_pulse();
      cclk = 1'b0;
      cycles(50);
      cclk = 1'b1;
      cycles(50);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int fd0;
      int ov0;
      fd0 = fd_cnt;
      ov0 = ov_cnt;
      button_state = v.buttons;
      latch_pulse();
      chk($sformatf("%s_snapshot", tag), 32'(snapshot), 32'(v.buttons));
      chk($sformatf("%s_state_shift", tag), 32'(fsm_state), 32'd2);
      chk($sformatf("%s_bit0", tag), 32'(data), 32'(v.exp_bits[0]));
      for (int i = 1; i <= v.pulses; i++) begin
         clock_pulse();
         chk($sformatf("%s_bit%0d", tag, i), 32'(data), 32'(v.exp_bits[i]));
      end
      chk($sformatf("%s_count", tag), 32'(bit_count), 32'(v.exp_count));
      chk($sformatf("%s_frame_done", tag), 32'(fd_cnt - fd0), 32'(v.exp_done));
      chk($sformatf("%s_overrun", tag), 32'(ov_cnt - ov0), 32'd0);
   endtask

   initial begin
      int fd0;
      int ov0;

      // Bit k of exp_bits is the data level read after k rising edges.
      vecs[0] = '{16'h0001, 16, 32'h0000_FFFE, 5'd16, 1};
      vecs[1] = '{16'hA5F0, 20, 32'h0000_5A0F, 5'd16, 1};
      vecs[2] = '{16'hFFFF, 16, 32'h0000_0000, 5'd16, 1};
      vecs[3] = '{16'h0000, 17, 32'h0000_FFFF, 5'd16, 1};
      vecs[4] = '{16'h1234, 5,  32'h0000_000B, 5'd5,  0};
      vecs[5] = '{16'h8000, 16, 32'h0000_7FFF, 5'd16, 1};

      reset        = 1'b1;
      latch        = 1'b0;
      cclk         = 1'b1;
      button_state = 16'h0000;
      cycles(3);
      chk("rst_data", 32'(data), 32'd1);
      chk("rst_count", 32'(bit_count), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_snapshot", 32'(snapshot), 32'd0);
      reset = 1'b0;
      cycles(100);
      chk("idle_data", 32'(data), 32'd1);
      chk("idle_count", 32'(bit_count), 32'd0);
      chk("idle_state", 32'(fsm_state), 32'd0);
      chk("idle_frame_done", 32'(fd_cnt), 32'd0);
      chk("idle_overrun", 32'(ov_cnt), 32'd0);

      for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Abort after 7 bits, then a full frame with new buttons.
      fd0 = fd_cnt;
      button_state = 16'h3C3C;
      latch_pulse();
      for (int i = 0; i < 7; i++) clock_pulse();
      chk("abort_count7", 32'(bit_count), 32'd7);
      run_vec(vecs[5], "abort_vec");
      chk("abort_total_done", 32'(fd_cnt - fd0), 32'd1);

      // Clock edges while latched do not shift and pulse overrun.
      fd0 = fd_cnt;
      button_state = 16'h0003;
      latch = 1'b1;
      cycles(50);
      chk("load_data", 32'(data), 32'd0);
      chk("load_count", 32'(bit_count), 32'd0);
      chk("load_state", 32'(fsm_state), 32'd1);
      button_state = 16'h0002;
      cycles(5);
      chk("load_transparent", 32'(data), 32'd1);
      ov0 = ov_cnt;
      cclk = 1'b0;
      cycles(50);
      cclk = 1'b1;
      cycles(10);
      chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
      chk("ovr_count", 32'(bit_count), 32'd0);
      chk("ovr_data", 32'(data), 32'd1);
      latch = 1'b0;
      cycles(50);
      chk("ovr_snapshot", 32'(snapshot), 32'h0002);
      cclk = 1'b0;
      cycles(50);
      ov0 = ov_cnt;
      latch = 1'b1;
      cclk  = 1'b1;
      cycles(10);
      chk("same_ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
      chk("same_count", 32'(bit_count), 32'd0);
      chk("same_data", 32'(data), 32'd1);
      chk("same_state", 32'(fsm_state), 32'd1);
      latch = 1'b0;
      cycles(50);
      chk("ovr_no_done", 32'(fd_cnt - fd0), 32'd0);

      // Asynchronous reset mid-frame after 9 bits.
      button_state = 16'h00FF;
      latch_pulse();
      for (int i = 0; i < 9; i++) clock_pulse();
      chk("midrst_count9", 32'(bit_count), 32'd9);
      fd0 = fd_cnt;
      @(posedge clk);
      #7 reset = 1'b1;
      #1;
      chk("midrst_data", 32'(data), 32'd1);
      chk("midrst_count", 32'(bit_count), 32'd0);
      chk("midrst_snapshot", 32'(snapshot), 32'd0);
      chk("midrst_state", 32'(fsm_state), 32'd0);
      #20 reset = 1'b0;
      cycles(10);
      for (int i = 0; i < 3; i++) begin
         clock_pulse();
         chk($sformatf("postrst_data%0d", i), 32'(data), 32'd1);
         chk($sformatf("postrst_count%0d", i), 32'(bit_count), 32'd0);
      end
      chk("postrst_no_done", 32'(fd_cnt - fd0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
